// File: rtl/ser_arbiter_pkg.sv
// ser_arbiter_pkg: shared FSM encoding and default sizes for the serial arbiter
package ser_arbiter_pkg;
  localparam int DW_DEF = 8;
  localparam int NREQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, LAST} state_t;
endpackage

// File: rtl/ser_shift.sv
// ser_shift: load/shift register with bit counter, emits one MSB-first serial frame
module ser_shift #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          start,
  input  logic [DW-1:0] din,
  output logic          data_out,
  output logic          e_out,
  output logic          done
);
  localparam int CW = DW > 1 ? $clog2(DW) : 1;
  logic [DW-1:0] sreg;
  logic [CW-1:0] cnt;
  assign done = start && cnt == CW'(DW - 1);
  // the word itself carries no reset; only control state is cleared
  always_ff @(posedge CLK)
    if (load) sreg <= din;
    else if (start) sreg <= sreg << 1;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      data_out <= 1'b0;
      e_out <= 1'b0;
    end else begin
      data_out <= start & sreg[DW-1];
      e_out <= start;
      cnt <= (load || done) ? '0 : start ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/ser_arbiter.sv
// ser_arbiter: round-robin arbiter that serializes the granted requester's word
module ser_arbiter
  import ser_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data_in,
  output logic [NREQ-1:0]          ack,
  output logic                     data_out,
  output logic                     e_out,
  output logic [$clog2(NREQ)-1:0]  src_id,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  state_t state, next_state;
  logic [IW-1:0] ptr, gnt_idx, idx;
  logic found, load, start, done;
  // search begins one past the last grant so every requester gets its turn
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ptr + IW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  always_comb begin
    load = (state == IDLE || state == LAST) && found;
    start = state == SHIFT;
    next_state = load ? SHIFT : start ? (done ? LAST : SHIFT) : IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      ptr <= IW'(NREQ - 1);
      ack <= '0;
      src_id <= '0;
      busy <= 1'b0;
    end else begin
      state <= next_state;
      ack <= load ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
      busy <= load || (busy && state != LAST);
      if (load) begin
        ptr <= gnt_idx;
        src_id <= gnt_idx;
      end
    end
  ser_shift #(.DW(DW)) u_shift (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .start(start),
    .din(data_in[gnt_idx*DW +: DW]),
    .data_out(data_out),
    .e_out(e_out),
    .done(done)
  );
endmodule
